// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches that consume its stream.
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP   = 2;
    localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Request/stream bundle between a pattern source (master) and the transmitter (slave).
interface serial_pattern_tx_if
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             control;
    logic             frame;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, repeat_cnt,
        input  control, frame, busy, done
    );

    modport slave (
        input  start, pattern, repeat_cnt,
        output control, frame, busy, done
    );

endinterface

// File: rtl/serial_pattern_tx_shreg.sv
// MSB-first shift register with a reload copy. msb is always the next bit to be presented;
// shifting while last_bit is set wraps back to the start of the reload copy.
module serial_pattern_tx_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb,
    output logic             last_bit
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    // sr holds the bits after the one currently on the wire; bit_idx indexes the wire bit.
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] reload;
    logic [IDX_W-1:0] bit_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr      <= '0;
            reload  <= '0;
            bit_idx <= '0;
        end else if (load) begin
            reload  <= data;
            sr      <= data << 1;
            bit_idx <= '0;
        end else if (shift) begin
            if (last_bit) begin
                sr      <= reload << 1;
                bit_idx <= '0;
            end else begin
                sr      <= sr << 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    assign last_bit = (bit_idx == LAST_IDX);
    assign msb      = last_bit ? reload[WIDTH-1] : sr[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first repeat_cnt+1 times with
// GAP idle cycles between frames, then pulses done.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    serial_pattern_tx_if.slave bus
);

    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] rep;
    logic [GAP_W-1:0] gap_cnt;
    logic             control_q;
    logic             frame_q;
    logic             busy_q;
    logic             done_q;

    logic load;
    logic shift;
    logic gap_end;
    logic msb;
    logic last_bit;

    assign gap_end = (state == S_GAP) && (gap_cnt == GAP_LAST);
    assign load    = (state == S_IDLE) && bus.start;
    // The shift register advances on every in-frame bit, on a back-to-back wrap, and when a gap ends.
    assign shift   = ((state == S_SHIFT) && (!last_bit || ((rep != '0) && (GAP == 0)))) || gap_end;

    serial_pattern_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .data     (bus.pattern),
        .msb      (msb),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rep       <= '0;
            gap_cnt   <= '0;
            control_q <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_SHIFT;
                        rep       <= bus.repeat_cnt;
                        control_q <= bus.pattern[WIDTH-1];
                        frame_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!last_bit) begin
                        control_q <= msb;
                    end else if (rep != '0) begin
                        rep <= rep - 1'b1;
                        if (GAP == 0) begin
                            control_q <= msb;
                        end else begin
                            state     <= S_GAP;
                            gap_cnt   <= '0;
                            control_q <= 1'b0;
                            frame_q   <= 1'b0;
                        end
                    end else begin
                        state     <= S_DONE;
                        control_q <= 1'b0;
                        frame_q   <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        state     <= S_SHIFT;
                        control_q <= msb;
                        frame_q   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.control = control_q;
    assign bus.frame   = frame_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: three instances with GAP = 2, 0 and 1.
module tb_serial_pattern_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_n;
    logic [2:0]       start;
    logic [2:0][7:0]  pat;
    logic [2:0][3:0]  rep;
    logic [2:0]       ctl, frm, bsy, dn;

    logic [2:0] exp_q [3][$];
    int exp_frames [3];
    int frame_cnt  [3];
    int done_cnt   [3];
    int done_base  [3];
    int checks = 0;
    int errors = 0;

    function automatic int gap_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 0 : 1;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", name, i, act, expv);
        end
    endtask

    // Expected busy-window stream per transaction, built from the frame/gap/done rules.
    function automatic void push(input int i, input logic [7:0] p, input int r);
        for (int f = 0; f <= r; f++) begin
            for (int k = 7; k >= 0; k--) exp_q[i].push_back({p[k], 1'b1, 1'b0});
            if (f < r) for (int g = 0; g < gap_of(i); g++) exp_q[i].push_back(3'b000);
        end
        exp_q[i].push_back(3'b001);
        exp_frames[i] = (gap_of(i) > 0) ? r + 1 : 1;
    endfunction

    function automatic int busy_len(input int i, input int r);
        return (r + 1) * 8 + r * gap_of(i) + 1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        serial_pattern_tx_if #(.WIDTH(8), .CNT_W(4)) bus ();

        serial_pattern_tx #(
            .WIDTH (8),
            .GAP   ((g == 0) ? 2 : (g == 1) ? 0 : 1),
            .CNT_W (4)
        ) dut (
            .clk   (clk),
            .reset (rst_n[g]),
            .bus   (bus)
        );

        assign bus.start      = start[g];
        assign bus.pattern    = pat[g];
        assign bus.repeat_cnt = rep[g];
        assign ctl[g] = bus.control;
        assign frm[g] = bus.frame;
        assign bsy[g] = bus.busy;
        assign dn[g]  = bus.done;

        logic prev_frm = 1'b0;

        always @(negedge clk) begin
            if (!rst_n[g]) begin
                frame_cnt[g] = 0;
            end else begin
                if (bsy[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_busy dut%0d actual=%b%b%b required=empty", g, ctl[g], frm[g], dn[g]);
                    end else begin
                        check("stream", g, 32'({ctl[g], frm[g], dn[g]}), 32'(exp_q[g].pop_front()));
                    end
                    if (frm[g] && !prev_frm) frame_cnt[g]++;
                    if (dn[g]) begin
                        done_cnt[g]++;
                        check("frame_count", g, 32'(frame_cnt[g]), 32'(exp_frames[g]));
                        frame_cnt[g] = 0;
                    end
                end else begin
                    check("idle", g, 32'({ctl[g], frm[g], dn[g]}), 32'd0);
                end
                prev_frm = frm[g];
            end
        end
    end

    task automatic start_txn(input int i, input logic [7:0] p, input int r);
        @(negedge clk);
        done_base[i] = done_cnt[i];
        pat[i]   = p;
        rep[i]   = 4'(r);
        start[i] = 1'b1;
        push(i, p, r);
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        check("accept", i, 32'(bsy[i]), 32'd1);
    endtask

    // Runs to the first idle cycle, scrambling inputs meanwhile; checks busy length and done count.
    task automatic wait_idle(input int i, input int n_done, input int len);
        int c = 0;
        @(negedge clk);
        while (bsy[i] && c < 1000) begin
            pat[i] = 8'($urandom);
            rep[i] = 4'($urandom);
            @(negedge clk);
            c++;
        end
        #2;
        check("busy_len", i, 32'(c), 32'(len));
        check("drain", i, 32'(exp_q[i].size()), 32'd0);
        check("done_count", i, 32'(done_cnt[i] - done_base[i]), 32'(n_done));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog dut-all actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = '0;
        start = '0;
        pat   = '0;
        rep   = '0;
        for (int i = 0; i < 3; i++) begin
            frame_cnt[i] = 0;
            done_cnt[i]  = 0;
            done_base[i] = 0;
        end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check("reset", i, 32'({ctl[i], frm[i], bsy[i], dn[i]}), 32'd0);
        #2 rst_n = '1;
        repeat (3) @(negedge clk);

        // Single frame, then repeat with gap
        start_txn(0, 8'b1011_0010, 0);
        wait_idle(0, 1, busy_len(0, 0));
        start_txn(0, 8'hA5, 1);
        wait_idle(0, 1, busy_len(0, 1));

        // Start pulsed during the 4th bit must be ignored
        start_txn(0, 8'h00, 0);
        repeat (3) @(posedge clk);
        #1;
        start[0] = 1'b1;
        pat[0]   = 8'hFF;
        rep[0]   = 4'hF;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_idle(0, 1, busy_len(0, 0) - 4);

        // Start held high: restart in the first idle cycle after done
        @(negedge clk);
        done_base[0] = done_cnt[0];
        pat[0] = 8'h3C;
        rep[0] = 4'd0;
        start[0] = 1'b1;
        push(0, 8'h3C, 0);
        push(0, 8'h3C, 0);
        seen = 1'b0;
        for (int c = 0; c < 40 && !(seen && !bsy[0]); c++) begin
            @(negedge clk);
            seen |= bsy[0];
        end
        #1;
        check("held_gap", 0, 32'(bsy[0]), 32'd0);
        @(negedge clk);
        #1;
        check("held_restart", 0, 32'(bsy[0]), 32'd1);
        start[0] = 1'b0;
        wait_idle(0, 2, busy_len(0, 0) - 1);

        // Asynchronous reset during the 3rd bit
        start_txn(0, 8'hFF, 0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_ctl", 0, 32'(ctl[0]), 32'd1);
        #1 rst_n[0] = 1'b0;
        #1;
        check("reset_ctl", 0, 32'(ctl[0]), 32'd0);
        check("reset_busy", 0, 32'(bsy[0]), 32'd0);
        check("reset_frame", 0, 32'(frm[0]), 32'd0);
        exp_q[0].delete();
        repeat (2) @(negedge clk);
        #2 rst_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        check("post_reset_idle", 0, 32'(bsy[0]), 32'd0);
        check("post_reset_done", 0, 32'(done_cnt[0] - done_base[0]), 32'd0);

        // Back-to-back frames with no gap
        start_txn(1, 8'hF0, 2);
        wait_idle(1, 1, busy_len(1, 2));

        // Maximum repeat count: 16 frames
        start_txn(2, 8'h81, 15);
        wait_idle(2, 1, busy_len(2, 15));

        // Randomized transactions on every instance
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 6; n++) begin
                int r;
                r = int'($urandom_range(0, 3));
                start_txn(i, 8'($urandom), r);
                wait_idle(i, 1, busy_len(i, r));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
